// File: rtl/pa_sched_pkg.sv
// Shared types and default geometry for the processing-array tile sequencer.
// The drain counter width helper keeps a zero-length drain from collapsing to a 0-bit vector.
package pa_sched_pkg;

    localparam int SIZE_MAT_DEF       = 16;
    localparam int WIDTH_DATA_DEF     = 16;
    localparam int WIDTH_LBIT_CNT_DEF = 6;
    localparam int WIDTH_HBIT_CNT_DEF = 3;
    localparam int DRAIN_CYC_DEF      = 2 * SIZE_MAT_DEF - 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FEED   = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_RESULT = 3'd3,
        ST_DONE   = 3'd4
    } pa_state_e;

    function automatic int drain_cnt_w(input int drain_cyc);
        return (drain_cyc > 0) ? $clog2(drain_cyc + 1) : 1;
    endfunction

endpackage

// File: rtl/pa_sched_cnt.sv
// Up-counter with synchronous clear (priority over enable) and a terminal-count
// flag that is high while the count equals the limit input.
module pa_sched_cnt
    import pa_sched_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] limit_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             tc_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == limit_i);

endmodule

// File: rtl/pa_sched.sv
// Tile sequencer: streams upstream vector pairs onto the array buses, pads each tile
// with zero drain cycles, then holds a result handshake before the next tile.
module pa_sched
    import pa_sched_pkg::*;
#(
    parameter int SIZE_MAT       = SIZE_MAT_DEF,
    parameter int WIDTH_DATA     = WIDTH_DATA_DEF,
    parameter int WIDTH_LBIT_CNT = WIDTH_LBIT_CNT_DEF,
    parameter int WIDTH_HBIT_CNT = WIDTH_HBIT_CNT_DEF,
    parameter int DRAIN_CYC      = 2 * SIZE_MAT - 2,
    localparam int BUS_W         = SIZE_MAT * WIDTH_DATA,
    localparam int DRAIN_W       = drain_cnt_w(DRAIN_CYC)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_i,
    input  logic [WIDTH_LBIT_CNT-1:0] k_len_i,
    input  logic [WIDTH_HBIT_CNT-1:0] n_tile_i,
    input  logic                      src_valid_i,
    input  logic [BUS_W-1:0]          v_src_i,
    input  logic [BUS_W-1:0]          h_src_i,
    output logic                      src_rd_o,
    input  logic                      pa_read_en_i,
    output logic                      pa_data_rdy_o,
    output logic [BUS_W-1:0]          v_bus_o,
    output logic [BUS_W-1:0]          h_bus_o,
    output logic                      bus_vld_o,
    output logic [WIDTH_HBIT_CNT-1:0] tile_idx_o,
    output logic                      res_valid_o,
    input  logic                      res_ready_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [2:0]                dbg_state_o,
    output logic [WIDTH_LBIT_CNT-1:0] dbg_k_cnt_o,
    output logic [DRAIN_W-1:0]        dbg_d_cnt_o
);

    // Handshakes: a pair moves on src_rd_o (= FEED & src_valid_i & pa_read_en_i), with no
    // back-pressure beyond that AND; a tile result moves on the edge where res_valid_o & res_ready_i.
    localparam logic [DRAIN_W-1:0] DRAIN_LIM = (DRAIN_CYC > 0) ? DRAIN_W'(DRAIN_CYC - 1) : '0;

    pa_state_e                 state_q, state_d;
    logic [WIDTH_LBIT_CNT-1:0] k_len_q, k_len_d;
    logic [WIDTH_HBIT_CNT-1:0] n_tile_q, n_tile_d;
    logic [BUS_W-1:0]          v_bus_q, v_bus_d;
    logic [BUS_W-1:0]          h_bus_q, h_bus_d;
    logic                      bus_vld_q, bus_vld_d;
    logic                      res_valid_q, res_valid_d;
    logic                      done_q, done_d;

    logic                      transfer;
    logic                      start_ok;
    logic                      res_hs;
    logic                      k_tc, d_tc, t_tc;
    logic                      k_clr, d_clr, t_clr;
    logic [WIDTH_HBIT_CNT-1:0] tile_cnt;

    assign transfer = (state_q == ST_FEED) & src_valid_i & pa_read_en_i;
    assign start_ok = (state_q == ST_IDLE) & start_i & (k_len_i != '0) & (n_tile_i != '0);
    assign res_hs   = (state_q == ST_RESULT) & res_ready_i;

    assign k_clr = start_ok | (res_hs & ~t_tc);
    assign d_clr = transfer & k_tc;
    assign t_clr = start_ok;

    pa_sched_cnt #(.WIDTH(WIDTH_LBIT_CNT)) u_k_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (k_clr),
        .en_i    (transfer),
        .limit_i (k_len_q - WIDTH_LBIT_CNT'(1)),
        .cnt_o   (dbg_k_cnt_o),
        .tc_o    (k_tc)
    );

    pa_sched_cnt #(.WIDTH(DRAIN_W)) u_d_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (d_clr),
        .en_i    (state_q == ST_DRAIN),
        .limit_i (DRAIN_LIM),
        .cnt_o   (dbg_d_cnt_o),
        .tc_o    (d_tc)
    );

    pa_sched_cnt #(.WIDTH(WIDTH_HBIT_CNT)) u_t_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (t_clr),
        .en_i    (res_hs & ~t_tc),
        .limit_i (n_tile_q - WIDTH_HBIT_CNT'(1)),
        .cnt_o   (tile_cnt),
        .tc_o    (t_tc)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_ok) state_d = ST_FEED;
            end
            ST_FEED: begin
                if (transfer && k_tc) state_d = (DRAIN_CYC == 0) ? ST_RESULT : ST_DRAIN;
            end
            ST_DRAIN: begin
                if (d_tc) state_d = ST_RESULT;
            end
            ST_RESULT: begin
                if (res_hs) state_d = t_tc ? ST_DONE : ST_FEED;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Lengths are captured only on an accepted start, so later input changes are ignored.
    always_comb begin
        k_len_d     = start_ok ? k_len_i : k_len_q;
        n_tile_d    = start_ok ? n_tile_i : n_tile_q;
        v_bus_d     = transfer ? v_src_i : '0;
        h_bus_d     = transfer ? h_src_i : '0;
        bus_vld_d   = transfer;
        res_valid_d = (state_d == ST_RESULT);
        done_d      = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            k_len_q     <= '0;
            n_tile_q    <= '0;
            v_bus_q     <= '0;
            h_bus_q     <= '0;
            bus_vld_q   <= 1'b0;
            res_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_len_q     <= k_len_d;
            n_tile_q    <= n_tile_d;
            v_bus_q     <= v_bus_d;
            h_bus_q     <= h_bus_d;
            bus_vld_q   <= bus_vld_d;
            res_valid_q <= res_valid_d;
            done_q      <= done_d;
        end
    end

    assign src_rd_o      = transfer;
    assign pa_data_rdy_o = (state_q == ST_FEED) | (state_q == ST_DRAIN);
    assign v_bus_o       = v_bus_q;
    assign h_bus_o       = h_bus_q;
    assign bus_vld_o     = bus_vld_q;
    assign tile_idx_o    = tile_cnt;
    assign res_valid_o   = res_valid_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign done_o        = done_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_pa_sched.sv
// Randomized bench for pa_sched: a job-level reference model (remaining-work counts and a
// queue of popped vector pairs) predicts every output each cycle; per-job totals are checked too.
module tb_pa_sched;
    import pa_sched_pkg::*;

    localparam int BUS_W = SIZE_MAT_DEF * WIDTH_DATA_DEF;
    localparam int KW    = WIDTH_LBIT_CNT_DEF;
    localparam int TW    = WIDTH_HBIT_CNT_DEF;
    localparam int DRAIN = 2 * SIZE_MAT_DEF - 2;
    localparam int DW    = drain_cnt_w(DRAIN);

    localparam int MP_IDLE = 0, MP_FEED = 1, MP_DRAIN = 2, MP_RESULT = 3, MP_DONE = 4;

    logic             clk, rst_n, start_i, src_valid_i, pa_read_en_i, res_ready_i;
    logic [KW-1:0]    k_len_i;
    logic [TW-1:0]    n_tile_i;
    logic [BUS_W-1:0] v_src_i, h_src_i, v_bus_o, h_bus_o;
    logic             src_rd_o, pa_data_rdy_o, bus_vld_o, res_valid_o, busy_o, done_o;
    logic [TW-1:0]    tile_idx_o;
    logic [2:0]       dbg_state_o;
    logic [KW-1:0]    dbg_k_cnt_o;
    logic [DW-1:0]    dbg_d_cnt_o;

    pa_sched dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_i),
        .k_len_i       (k_len_i),
        .n_tile_i      (n_tile_i),
        .src_valid_i   (src_valid_i),
        .v_src_i       (v_src_i),
        .h_src_i       (h_src_i),
        .src_rd_o      (src_rd_o),
        .pa_read_en_i  (pa_read_en_i),
        .pa_data_rdy_o (pa_data_rdy_o),
        .v_bus_o       (v_bus_o),
        .h_bus_o       (h_bus_o),
        .bus_vld_o     (bus_vld_o),
        .tile_idx_o    (tile_idx_o),
        .res_valid_o   (res_valid_o),
        .res_ready_i   (res_ready_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .dbg_state_o   (dbg_state_o),
        .dbg_k_cnt_o   (dbg_k_cnt_o),
        .dbg_d_cnt_o   (dbg_d_cnt_o)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int pops_seen, dones_seen, busy_seen, rv_first;
    bit chk_en  = 1'b0;

    // stimulus modes: valid 0=held 1, 1=random; rd 0=held 1, 1=toggle, 2=random;
    // ready 0=held 1, 1=hold 0 for five result cycles, 2=random
    int valid_mode, rd_mode, ready_mode;
    bit tgl;
    int hold_cnt;

    // ---------------- reference model ----------------
    int               m_phase;
    int               m_klen, m_ntile, m_tile, m_pops_left, m_drain_left;
    bit               m_vld;
    logic [2*BUS_W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [BUS_W-1:0] got, input logic [BUS_W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [BUS_W-1:0] rand_bus();
        logic [BUS_W-1:0] r;
        for (int i = 0; i < BUS_W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic check_all();
        logic [BUS_W-1:0]   ev, eh;
        logic [2*BUS_W-1:0] pair;
        bit                 exp_pop;
        exp_pop = (m_phase == MP_FEED) && src_valid_i && pa_read_en_i;
        ev = '0;
        eh = '0;
        if (m_vld && exp_q.size() > 0) begin
            pair = exp_q.pop_front();
            ev   = pair[2*BUS_W-1:BUS_W];
            eh   = pair[BUS_W-1:0];
        end
        check("src_rd", src_rd_o, exp_pop);
        check("bus_vld", bus_vld_o, m_vld);
        check("v_bus", v_bus_o, ev);
        check("h_bus", h_bus_o, eh);
        check("data_rdy", pa_data_rdy_o, (m_phase == MP_FEED) || (m_phase == MP_DRAIN));
        check("res_valid", res_valid_o, m_phase == MP_RESULT);
        check("busy", busy_o, m_phase != MP_IDLE);
        check("done", done_o, m_phase == MP_DONE);
        check("tile_idx", tile_idx_o, BUS_W'(m_tile));
    endtask

    task automatic model_step();
        bit pop;
        if (!rst_n) begin
            m_phase = MP_IDLE;
            m_tile = 0;
            m_vld = 1'b0;
            m_pops_left = 0;
            m_drain_left = 0;
            exp_q.delete();
            return;
        end
        pop = (m_phase == MP_FEED) && src_valid_i && pa_read_en_i;
        m_vld = pop;
        if (pop) exp_q.push_back({v_src_i, h_src_i});
        case (m_phase)
            MP_IDLE: if (start_i && k_len_i != 0 && n_tile_i != 0) begin
                m_klen = int'(k_len_i);
                m_ntile = int'(n_tile_i);
                m_tile = 0;
                m_pops_left = m_klen;
                m_phase = MP_FEED;
            end
            MP_FEED: if (pop) begin
                m_pops_left--;
                if (m_pops_left == 0) begin
                    m_drain_left = DRAIN;
                    m_phase = (DRAIN > 0) ? MP_DRAIN : MP_RESULT;
                end
            end
            MP_DRAIN: begin
                m_drain_left--;
                if (m_drain_left == 0) m_phase = MP_RESULT;
            end
            MP_RESULT: if (res_ready_i) begin
                if (m_tile == m_ntile - 1) begin
                    m_phase = MP_DONE;
                end else begin
                    m_tile++;
                    m_pops_left = m_klen;
                    m_phase = MP_FEED;
                end
            end
            default: m_phase = MP_IDLE;
        endcase
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        if (chk_en) check_all();
        if (src_rd_o === 1'b1) pops_seen++;
        if (done_o === 1'b1) dones_seen++;
        if (busy_o === 1'b1) busy_seen++;
        if (res_valid_o === 1'b1 && rv_first < 0) rv_first = cyc;
        @(posedge clk);
        model_step();
        chk_en = 1'b1;
        #1;
        cyc++;
    endtask

    task automatic drive_cycle();
        src_valid_i = (valid_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
        case (rd_mode)
            0: pa_read_en_i = 1'b1;
            1: begin pa_read_en_i = tgl; tgl = ~tgl; end
            default: pa_read_en_i = $urandom_range(0, 1) != 0;
        endcase
        case (ready_mode)
            0: res_ready_i = 1'b1;
            1: begin
                if (m_phase == MP_RESULT) begin
                    res_ready_i = (hold_cnt >= 5);
                    hold_cnt++;
                end else begin
                    res_ready_i = 1'b0;
                    hold_cnt = 0;
                end
            end
            default: res_ready_i = $urandom_range(0, 2) != 0;
        endcase
        v_src_i = rand_bus();
        h_src_i = rand_bus();
        tick();
    endtask

    // Runs one job; poke_drain pulses a second start during DRAIN, rst_pops resets after that many pops.
    task automatic run_job(input int k, input int n, input bit poke_drain, input int rst_pops,
                           output int start_cyc);
        bit poked;
        int budget;
        pops_seen = 0;
        dones_seen = 0;
        busy_seen = 0;
        rv_first = -1;
        poked = 1'b0;
        start_cyc = cyc;
        start_i = 1'b1;
        k_len_i = KW'(k);
        n_tile_i = TW'(n);
        drive_cycle();
        start_i = 1'b0;
        k_len_i = KW'($urandom);
        n_tile_i = TW'($urandom);
        budget = 20000;
        while (m_phase != MP_IDLE && budget > 0) begin
            if (rst_pops > 0 && pops_seen >= rst_pops) begin
                rst_n = 1'b0;
                drive_cycle();
                rst_n = 1'b1;
                break;
            end
            if (poke_drain && !poked && m_phase == MP_DRAIN) begin
                start_i = 1'b1;
                k_len_i = 5;
                n_tile_i = 2;
                poked = 1'b1;
            end
            drive_cycle();
            start_i = 1'b0;
            budget--;
        end
        if (budget == 0) check("job_timeout", BUS_W'(m_phase), BUS_W'(MP_IDLE));
        repeat (2) drive_cycle();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int sc;
        int k, n;
        rst_n = 1'b0;
        start_i = 1'b0;
        k_len_i = '0;
        n_tile_i = '0;
        src_valid_i = 1'b0;
        pa_read_en_i = 1'b0;
        res_ready_i = 1'b0;
        v_src_i = '0;
        h_src_i = '0;
        m_phase = MP_IDLE;
        m_tile = 0;
        m_vld = 1'b0;
        valid_mode = 0;
        rd_mode = 0;
        ready_mode = 0;
        tgl = 1'b0;
        hold_cnt = 0;
        pops_seen = 0;
        dones_seen = 0;
        busy_seen = 0;
        rv_first = -1;
        repeat (3) drive_cycle();
        rst_n = 1'b1;
        drive_cycle();

        // single uninterrupted tile
        run_job(16, 1, 1'b0, 0, sc);
        check("single_pops", pops_seen, 16);
        check("single_rv_lat", rv_first - sc, 1 + 16 + DRAIN);
        check("single_dones", dones_seen, 1);

        // read_en toggling
        rd_mode = 1;
        tgl = 1'b0;
        run_job(4, 1, 1'b0, 0, sc);
        check("stall_pops", pops_seen, 4);
        check("stall_dones", dones_seen, 1);

        // multi-tile with held result
        rd_mode = 0;
        ready_mode = 1;
        run_job(2, 3, 1'b0, 0, sc);
        check("multi_pops", pops_seen, 6);
        check("multi_dones", dones_seen, 1);
        ready_mode = 0;

        // zero lengths are ignored
        run_job(0, 3, 1'b0, 0, sc);
        run_job(3, 0, 1'b0, 0, sc);
        check("zero_busy", busy_seen, 0);
        check("zero_pops", pops_seen, 0);
        check("zero_dones", dones_seen, 0);

        // reset mid-FEED, then a full tile
        run_job(16, 1, 1'b0, 5, sc);
        check("rst_dones", dones_seen, 0);
        run_job(16, 1, 1'b0, 0, sc);
        check("after_rst_pops", pops_seen, 16);
        check("after_rst_dones", dones_seen, 1);

        // start during DRAIN is ignored
        run_job(3, 1, 1'b1, 0, sc);
        check("poke_pops", pops_seen, 3);
        check("poke_dones", dones_seen, 1);

        // max K and max tiles with random pacing
        valid_mode = 1;
        rd_mode = 2;
        ready_mode = 2;
        run_job(63, 7, 1'b0, 0, sc);
        check("max_pops", pops_seen, 441);
        check("max_dones", dones_seen, 1);

        // a few random jobs
        for (int j = 0; j < 6; j++) begin
            k = $urandom_range(1, 12);
            n = $urandom_range(1, 4);
            run_job(k, n, 1'b0, 0, sc);
            check("rand_pops", pops_seen, k * n);
            check("rand_dones", dones_seen, 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pa_sched.md
# pa_sched

Tile sequencer for the 16x16 processing array (`pa_top`).
- Pops operand vector pairs from an upstream source and streams them onto the array's vertical and horizontal buses, paced by the array's `read_en` request.
- After each tile it inserts zero-padded drain cycles so partial sums leave the array.
- It then holds a result handshake per tile before moving to the next tile.
- One `start_i` runs `n_tile_i` tiles of `k_len_i` vectors each.

## Interface
- `SIZE_MAT`, 16, array edge length (lanes per bus)
- `WIDTH_DATA`, 16, lane width
- `WIDTH_LBIT_CNT`, 6, width of the K (vectors-per-tile) counter
- `WIDTH_HBIT_CNT`, 3, width of the tile counter
- `DRAIN_CYC`, 2*SIZE_MAT-2, zero cycles appended after each tile's last vector

- `clk`  in  1  clock
- `rst_n`  in  1  reset: synchronous, active-low
- `start_i`  in  1  start pulse; sampled only in IDLE
- `k_len_i`  in  WIDTH_LBIT_CNT  vectors per tile; latched at start
- `n_tile_i`  in  WIDTH_HBIT_CNT  tile count; latched at start
- `src_valid_i`  in  1  upstream vector pair available
- `v_src_i`, `h_src_i`  in  SIZE_MAT*WIDTH_DATA  upstream vertical/horizontal vectors
- `src_rd_o`  out  1  pop upstream pair this cycle
- `pa_read_en_i`  in  1  array requests next vector (`pa_top.read_en_o`)
- `pa_data_rdy_o`  out  1  drives `pa_top.data_rdy_i`
- `v_bus_o`, `h_bus_o`  out  SIZE_MAT*WIDTH_DATA  registered buses to array
- `bus_vld_o`  out  1  buses carry a real operand this cycle
- `tile_idx_o`  out  WIDTH_HBIT_CNT  current tile index
- `res_valid_o`  out  1  tile result ready in array
- `res_ready_i`  in  1  consumer accepts tile result
- `busy_o`  out  1  state != IDLE
- `done_o`  out  1  one-cycle pulse at job end

## Operation
- States: IDLE, FEED, DRAIN, RESULT, DONE.
- **IDLE**
  - `start_i & k_len_i!=0 & n_tile_i!=0`: latch `k_len_i` and `n_tile_i`, clear `k_cnt`/`tile_cnt`, go to FEED.
  - `start_i` with either length zero is ignored; the block stays in IDLE with no `done_o`.
- **FEED**
  - Transfer when `src_valid_i & pa_read_en_i`; `src_rd_o` is that AND, combinational, asserted only in FEED.
  - On transfer: buses load `v_src_i`/`h_src_i`, `bus_vld_o`<=1, `k_cnt`++.
  - No transfer: buses load 0, `bus_vld_o`<=0 (bubble). Bubbles do not advance `k_cnt`.
  - Transfer with `k_cnt==k_len-1`: go to DRAIN with `d_cnt`=0.
- **DRAIN**
  - Buses load 0, `bus_vld_o`<=0, `src_rd_o`=0.
  - `d_cnt` increments every cycle regardless of `pa_read_en_i`.
  - At `d_cnt==DRAIN_CYC-1`: go to RESULT.
  - `DRAIN_CYC`=0 skips DRAIN entirely (FEED goes straight to RESULT).
- **RESULT**
  - `res_valid_o`=1 until `res_valid_o & res_ready_i`.
  - On handshake: if `tile_cnt==n_tile-1` go to DONE, else `tile_cnt`++, `k_cnt`=0, go to FEED.
- **DONE**: `done_o`=1 for one cycle, then IDLE.
- `pa_data_rdy_o` = 1 in FEED and DRAIN, 0 otherwise.
- `tile_idx_o` = `tile_cnt`.
- Latched lengths ignore input changes while busy; `start_i` while busy is ignored.
- Counters compare against latched values and never wrap: max K = 2^WIDTH_LBIT_CNT-1 = 63, max tiles = 7.

## Timing
- Reset (any state, mid-tile included): state IDLE; all counters 0; `v_bus_o`/`h_bus_o` 0; `bus_vld_o`, `src_rd_o`, `pa_data_rdy_o`, `res_valid_o`, `busy_o`, `done_o` all 0; `tile_idx_o` 0. Any partial tile is discarded.
- `start_i` sampled at edge T: state FEED from T+1. `src_rd_o` can first be high in cycle T+1.
- Latency from `src_rd_o` to data on the buses is 1 cycle (registered).
- Uninterrupted tile (no bubbles): FEED lasts `k_len` cycles, DRAIN lasts `DRAIN_CYC` cycles, `res_valid_o` rises `1+k_len+DRAIN_CYC` cycles after start.
- Handshake in RESULT at edge R:
  - next tile: FEED from R+1;
  - last tile: `done_o` high in cycle R+1, IDLE at R+2.
- `res_valid_o` and `done_o` are registered state decodes; `src_rd_o` is the only combinational output.

## Structure
- Package `pa_sched_pkg`: state enum (`ST_IDLE`, `ST_FEED`, `ST_DRAIN`, `ST_RESULT`, `ST_DONE`); default constants for `SIZE_MAT`, `WIDTH_DATA`, `WIDTH_LBIT_CNT`, `WIDTH_HBIT_CNT`; `DRAIN_CYC` default.
- One sub-module: `pa_sched_cnt`, a parameterized-width counter with clear, enable, and terminal-count compare against a limit input. It is instantiated three times (K, drain, tile).
- Drain counter width is `$clog2(DRAIN_CYC+1)`.

## Test plan
- **Single tile:** `k_len`=16, `n_tile`=1, `src_valid_i` and `pa_read_en_i` held 1. Expect:
  - `src_rd_o` high 16 consecutive cycles;
  - bus vectors appear in order 1 cycle later;
  - 30 zero cycles;
  - `res_valid_o` at start+47;
  - `res_ready_i`=1 gives `done_o` one cycle later.
- **Stalls:** `k_len`=4, `pa_read_en_i` toggling 1,0,1,0. Expect:
  - exactly 4 pops;
  - zero bubbles with `bus_vld_o`=0 between them;
  - DRAIN starts only after the 4th pop.
- **Multi-tile with held result:** `n_tile`=3, `k_len`=2, `res_ready_i` held 0 for 5 cycles per tile. Expect:
  - `res_valid_o` stays high and no pops during the hold;
  - `tile_idx_o` steps 0, 1, 2;
  - a single `done_o` at the end.
- **Zero lengths:** `start_i` with `k_len`=0, then with `n_tile`=0. Expect `busy_o` stays 0, no `src_rd_o`, no `done_o`.
- **Reset mid-FEED:** `rst_n`=0 after the 5th pop of a 16-vector tile. Expect all outputs 0 next cycle; a new start runs a full tile normally.
- **Start while busy and max K:** `start_i` pulsed in DRAIN is ignored. Then `k_len`=63, `n_tile`=7 completes with exactly 441 pops and one `done_o`.
